// File: rtl/cpu_pkg.sv
// Shared definitions for the 6-bit CPU datapath: status-flag layout and reset defaults.
package cpu_pkg;

    localparam int unsigned FLAG_CF = 2;
    localparam int unsigned FLAG_SF = 1;
    localparam int unsigned FLAG_ZF = 0;

    typedef logic [2:0] flags_t;

    localparam flags_t FLAGS_RESET = 3'b000;

endpackage

// File: rtl/flag_register.sv
// Status-flag register: captures ALU carry/sign/zero each rising edge and holds them
// for the next instruction's condition evaluation. Pure storage, no flag computation.
module flag_register
    import cpu_pkg::*;
#(
    parameter logic RESET_CF = FLAGS_RESET[FLAG_CF],
    parameter logic RESET_SF = FLAGS_RESET[FLAG_SF],
    parameter logic RESET_ZF = FLAGS_RESET[FLAG_ZF]
) (
    // Legacy positional order: rst last so 7-port instances still bind.
    input  logic cf,
    input  logic sf,
    input  logic zf,
    input  logic clk,
    output logic cf_out,
    output logic sf_out,
    output logic zf_out,
    input  logic rst
);

    flags_t flags_d;
    flags_t flags_q;
    flags_t reset_flags;

    always_comb begin
        reset_flags          = '0;
        reset_flags[FLAG_CF] = RESET_CF;
        reset_flags[FLAG_SF] = RESET_SF;
        reset_flags[FLAG_ZF] = RESET_ZF;
    end

    always_comb begin
        flags_d          = '0;
        flags_d[FLAG_CF] = cf;
        flags_d[FLAG_SF] = sf;
        flags_d[FLAG_ZF] = zf;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= reset_flags;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign cf_out = flags_q[FLAG_CF];
    assign sf_out = flags_q[FLAG_SF];
    assign zf_out = flags_q[FLAG_ZF];

endmodule

// File: tb/tb_flag_register.sv
// Self-checking bench for flag_register: directed cases plus randomized traffic
// against a simple "outputs = inputs seen at last edge, or reset value" model.
module tb_flag_register;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic cf, sf, zf;
    logic cf_out, sf_out, zf_out;
    logic cf_out_z, sf_out_z, zf_out_z;

    int unsigned checks = 0;
    int unsigned errors = 0;

    flags_t exp_a;
    flags_t exp_z;
    localparam flags_t RST_A = 3'b000;
    localparam flags_t RST_Z = 3'b001;

    always #5 clk = ~clk;

    flag_register dut (
        .cf(cf), .sf(sf), .zf(zf), .clk(clk),
        .cf_out(cf_out), .sf_out(sf_out), .zf_out(zf_out), .rst(rst)
    );

    flag_register #(.RESET_ZF(1'b1)) dut_z (
        .cf(cf), .sf(sf), .zf(zf), .clk(clk),
        .cf_out(cf_out_z), .sf_out(sf_out_z), .zf_out(zf_out_z), .rst(rst)
    );

    task automatic check_flags(input string tag, input flags_t got, input flags_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_both(input string tag);
        check_flags({tag, "_a"}, {cf_out, sf_out, zf_out}, exp_a);
        check_flags({tag, "_z"}, {cf_out_z, sf_out_z, zf_out_z}, exp_z);
    endtask

    task automatic drive(input flags_t f);
        {cf, sf, zf} = f;
    endtask

    // Wait for a rising edge; model captures the inputs present at that edge unless in reset.
    task automatic step();
        @(posedge clk);
        if (!rst) begin
            exp_a = {cf, sf, zf};
            exp_z = {cf, sf, zf};
        end
        #1;
    endtask

    task automatic assert_reset();
        rst   = 1'b1;
        exp_a = RST_A;
        exp_z = RST_Z;
    endtask

    initial begin
        flags_t r;
        {cf, sf, zf} = 3'b000;
        #2;
        assert_reset();
        #1;
        check_both("por_reset");

        // load all set
        @(negedge clk);
        rst = 1'b0;
        drive(3'b111);
        step();
        check_both("load_111");

        // hold between edges
        #1 drive(3'b010);
        #1 check_both("hold_mid1");
        drive(3'b101);
        @(negedge clk);
        check_both("hold_mid2");

        // partial update
        drive(3'b001);
        step();
        check_both("partial_001");

        // async reset between edges, then edges ignored while held
        @(negedge clk);
        drive(3'b111);
        step();
        check_both("reload_111");
        #2 assert_reset();
        #1 check_both("async_reset");
        step();
        check_both("reset_hold_edge");

        // reset released in the same timestep as a rising edge
        @(posedge clk);
        rst <= 1'b0;
        #1 check_both("release_edge");
        step();
        check_both("after_release");

        // randomized traffic with occasional async reset pulses and mid-cycle toggles
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            r = flags_t'($urandom);
            drive(r);
            if ($urandom_range(7) == 0) begin
                #1 assert_reset();
                #1 check_both("rand_async");
                rst = 1'b0;
            end
            step();
            check_both("rand_edge");
            #1 drive(flags_t'($urandom));
            #1 check_both("rand_hold");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
